// File: rtl/fft_address_sequencer.sv
// fft_address_sequencer: operand-address generator for an in-place radix-2
// DIT FFT. On start it walks every stage s and butterfly j of an N-point
// transform and, per butterfly, emits the sample-RAM word addresses of
// operands A and B (real/imag interleaved) over a valid/ready handshake.
//
// Ports
//   clk, nrst             clock (rising edge), async active-low reset
//   start, real_only      begin transform (IDLE only); real-part-only mode
//   abort                 synchronous return to IDLE
//   addr_ready            consumer accepts the current address
//   addr, addr_valid      operand word address and its valid
//   slot, stage, twiddle  0=A re,1=A im,2=B re,3=B im; FFT stage; W_N^k exponent
//   last_bfly             final slot of the current butterfly
//   busy, done            high in RUN; one-cycle completion pulse
module fft_address_sequencer #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LOG2_N    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                                          clk,
    input  logic                                          nrst,
    input  logic                                          start,
    input  logic                                          real_only,
    input  logic                                          abort,
    input  logic                                          addr_ready,
    output logic [ADDR_W-1:0]                             addr,
    output logic                                          addr_valid,
    output logic [1:0]                                    slot,
    output logic [((LOG2_N > 1) ? $clog2(LOG2_N) : 1)-1:0] stage,
    output logic [((LOG2_N > 1) ? LOG2_N - 1 : 1)-1:0]     twiddle,
    output logic                                          last_bfly,
    output logic                                          busy,
    output logic                                          done
);

    localparam int unsigned SW     = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;
    localparam int unsigned TW     = (LOG2_N > 1) ? LOG2_N - 1 : 1;
    localparam int unsigned JW     = (LOG2_N > 1) ? LOG2_N - 1 : 1;
    localparam int unsigned HALF_N = 32'd1 << (LOG2_N - 1);

    localparam logic [SW-1:0] STG_LAST  = SW'(LOG2_N - 1);
    localparam logic [JW-1:0] BFLY_LAST = JW'(HALF_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   stg_q, stg_d;
    logic [JW-1:0]   bfly_q, bfly_d;
    logic [1:0]      slot_q, slot_d;
    logic            ro_q, ro_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0]     tw_q, tw_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_q, last_d;

    logic              hsk;
    logic              run_d;
    logic [1:0]        last_slot_q;

    logic [ADDR_W-1:0] half_w, j_w, pos_w, grp_w, a_w, b_w, idx_w;
    logic [31:0]       tw_sh;

    assign hsk         = valid_q & addr_ready;
    assign last_slot_q = ro_q ? 2'd2 : 2'd3;

    // Next-state: counters advance one slot per handshake, nesting slot -> j -> s
    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        bfly_d  = bfly_q;
        slot_d  = slot_q;
        ro_d    = ro_q;

        case (state_q)
            S_IDLE: begin
                if (!abort && start) begin
                    state_d = S_RUN;
                    ro_d    = real_only;
                    stg_d   = '0;
                    bfly_d  = '0;
                    slot_d  = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    stg_d   = '0;
                    bfly_d  = '0;
                    slot_d  = '0;
                end else if (hsk) begin
                    if (slot_q == last_slot_q) begin
                        slot_d = '0;
                        if (bfly_q == BFLY_LAST) begin
                            bfly_d = '0;
                            if (stg_q == STG_LAST) begin
                                state_d = S_DONE;
                                stg_d   = '0;
                            end else begin
                                stg_d = stg_q + SW'(1);
                            end
                        end else begin
                            bfly_d = bfly_q + JW'(1);
                        end
                    end else begin
                        // real_only jumps straight from A real to B real
                        slot_d = ro_q ? 2'd2 : slot_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                stg_d   = '0;
                bfly_d  = '0;
                slot_d  = '0;
            end
        endcase
    end

    // Butterfly index math on the next-state counters so outputs are registered
    always_comb begin
        run_d  = (state_d == S_RUN);
        half_w = ADDR_W'(1) << stg_d;
        j_w    = ADDR_W'(bfly_d);
        pos_w  = j_w & (half_w - ADDR_W'(1));
        grp_w  = j_w >> stg_d;
        a_w    = ((grp_w << stg_d) << 1) | pos_w;
        b_w    = a_w + half_w;
        idx_w  = slot_d[1] ? b_w : a_w;
        tw_sh  = 32'(LOG2_N - 1) - 32'(stg_d);

        addr_d  = '0;
        tw_d    = '0;
        last_d  = 1'b0;
        valid_d = run_d;
        busy_d  = run_d;
        done_d  = (state_d == S_DONE);
        if (run_d) begin
            addr_d = ADDR_W'(BASE_ADDR) + (idx_w << 1) + ADDR_W'(slot_d[0]);
            tw_d   = TW'(pos_w << tw_sh);
            last_d = (slot_d == (ro_d ? 2'd2 : 2'd3));
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            stg_q   <= '0;
            bfly_q  <= '0;
            slot_q  <= '0;
            ro_q    <= 1'b0;
            addr_q  <= '0;
            tw_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            bfly_q  <= bfly_d;
            slot_q  <= slot_d;
            ro_q    <= ro_d;
            addr_q  <= addr_d;
            tw_q    <= tw_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    // Counters are cleared outside RUN, so slot/stage read zero there
    assign addr       = addr_q;
    assign addr_valid = valid_q;
    assign slot       = slot_q;
    assign stage      = stg_q;
    assign twiddle    = tw_q;
    assign last_bfly  = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fft_address_sequencer.sv
// Bench for fft_address_sequencer: an N=8 instance for sequence/mode/abort/
// reset checks and an N=256, BASE=1000 instance for address wrap.
module tb_fft_address_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic nrst;

    // N=8 instance
    logic       a_start, a_ro, a_abort, a_ready;
    logic [9:0] a_addr;
    logic       a_valid, a_last, a_busy, a_done;
    logic [1:0] a_slot, a_stage, a_tw;

    // N=256 wrap instance
    logic       b_start, b_ro, b_abort, b_ready;
    logic [9:0] b_addr;
    logic       b_valid, b_last, b_busy, b_done;
    logic [1:0] b_slot;
    logic [2:0] b_stage;
    logic [6:0] b_tw;

    fft_address_sequencer #(.ADDR_W(10), .LOG2_N(3), .BASE_ADDR(0)) dut_a (
        .clk(clk), .nrst(nrst), .start(a_start), .real_only(a_ro), .abort(a_abort),
        .addr_ready(a_ready), .addr(a_addr), .addr_valid(a_valid), .slot(a_slot),
        .stage(a_stage), .twiddle(a_tw), .last_bfly(a_last), .busy(a_busy), .done(a_done)
    );

    fft_address_sequencer #(.ADDR_W(10), .LOG2_N(8), .BASE_ADDR(1000)) dut_b (
        .clk(clk), .nrst(nrst), .start(b_start), .real_only(b_ro), .abort(b_abort),
        .addr_ready(b_ready), .addr(b_addr), .addr_valid(b_valid), .slot(b_slot),
        .stage(b_stage), .twiddle(b_tw), .last_bfly(b_last), .busy(b_busy), .done(b_done)
    );

    typedef struct {
        int addr;
        int slot;
        int stage;
        int tw;
        int last;
    } xfer_t;

    typedef struct {
        bit ro;
        int n;
        int addr;
        int slot;
        int stage;
        int tw;
        int last;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state (written only by the monitor)
    xfer_t cap[$];
    int    cyc = 0, last_hs_cyc = -10, done_cyc = -10, done_cnt = 0;
    int    hold_seen = 0, hold_bad = 0;
    bit    hold_pend = 1'b0;
    int    h_addr = 0, h_slot = 0, h_tw = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (hold_pend && a_valid) begin
            hold_seen <= hold_seen + 1;
            if (int'(a_addr) != h_addr || int'(a_slot) != h_slot || int'(a_tw) != h_tw)
                hold_bad <= hold_bad + 1;
        end
        hold_pend <= a_valid && !a_ready;
        h_addr    <= int'(a_addr);
        h_slot    <= int'(a_slot);
        h_tw      <= int'(a_tw);
        if (a_valid && a_ready) begin
            cap.push_back('{int'(a_addr), int'(a_slot), int'(a_stage), int'(a_tw), int'(a_last)});
            last_hs_cyc <= cyc;
        end
        if (a_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference for N=8, BASE=0 written straight from the DIT index formulas
    function automatic xfer_t model_a(input int n, input bit ro);
        xfer_t e;
        int per, bf, k, sl, s, j, half, grp, pos, a, b, idx;
        per  = ro ? 2 : 4;
        bf   = n / per;
        k    = n % per;
        sl   = ro ? 2 * k : k;
        s    = bf / 4;
        j    = bf % 4;
        half = 1 << s;
        grp  = j / half;
        pos  = j % half;
        a    = grp * 2 * half + pos;
        b    = a + half;
        idx  = (sl >= 2) ? b : a;
        e.addr  = (2 * idx + sl % 2) % 1024;
        e.slot  = sl;
        e.stage = s;
        e.tw    = pos * (1 << (2 - s));
        e.last  = (sl == (ro ? 2 : 3)) ? 1 : 0;
        return e;
    endfunction

    // Run one N=8 transform; start held `hold` cycles into RUN, real_only flipped mid-run
    task automatic run_a(input bit ro, input bit bp, input int hold,
                         output int base, output int d0, output int ok);
        base = cap.size();
        d0   = done_cnt;
        ok   = 0;
        @(posedge clk); #1;
        a_start = 1'b1;
        a_ro    = ro;
        a_ready = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (i >= hold) a_start = 1'b0;
            a_ro    = ~ro;
            a_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        a_start = 1'b0;
        a_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag, input bit ro, input int base,
                             input int d0, input int ok, input vec_t vecs[24]);
        int total, got;
        xfer_t e, g;
        total = ro ? 24 : 48;
        got   = cap.size() - base;
        check({tag, "_completed"}, ok, 1);
        check({tag, "_transfers"}, got, total);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_done_latency"}, done_cyc - last_hs_cyc, 1);
        for (int v = 0; v < 24; v++) begin
            if (vecs[v].ro == ro && vecs[v].n < got) begin
                g = cap[base + vecs[v].n];
                check($sformatf("%s_vec%0d_addr", tag, vecs[v].n), g.addr, vecs[v].addr);
                check($sformatf("%s_vec%0d_slot", tag, vecs[v].n), g.slot, vecs[v].slot);
                check($sformatf("%s_vec%0d_stage", tag, vecs[v].n), g.stage, vecs[v].stage);
                check($sformatf("%s_vec%0d_tw", tag, vecs[v].n), g.tw, vecs[v].tw);
                check($sformatf("%s_vec%0d_last", tag, vecs[v].n), g.last, vecs[v].last);
            end
        end
        for (int n = 0; n < total && n < got; n++) begin
            e = model_a(n, ro);
            g = cap[base + n];
            check($sformatf("%s_seq%0d_addr", tag, n), g.addr, e.addr);
            check($sformatf("%s_seq%0d_slot", tag, n), g.slot, e.slot);
            check($sformatf("%s_seq%0d_stage", tag, n), g.stage, e.stage);
            check($sformatf("%s_seq%0d_tw", tag, n), g.tw, e.tw);
            check($sformatf("%s_seq%0d_last", tag, n), g.last, e.last);
        end
    endtask

    initial begin
        vec_t vecs[24];
        int base, d0, ok, hb0;

        // {ro, transfer#, addr, slot, stage, twiddle, last_bfly}
        vecs[0]  = '{1'b0,  0,  0, 0, 0, 0, 0};
        vecs[1]  = '{1'b0,  1,  1, 1, 0, 0, 0};
        vecs[2]  = '{1'b0,  2,  2, 2, 0, 0, 0};
        vecs[3]  = '{1'b0,  3,  3, 3, 0, 0, 1};
        vecs[4]  = '{1'b0,  4,  4, 0, 0, 0, 0};
        vecs[5]  = '{1'b0, 15, 15, 3, 0, 0, 1};
        vecs[6]  = '{1'b0, 20,  2, 0, 1, 2, 0};
        vecs[7]  = '{1'b0, 21,  3, 1, 1, 2, 0};
        vecs[8]  = '{1'b0, 22,  6, 2, 1, 2, 0};
        vecs[9]  = '{1'b0, 23,  7, 3, 1, 2, 1};
        vecs[10] = '{1'b0, 24,  8, 0, 1, 0, 0};
        vecs[11] = '{1'b0, 26, 12, 2, 1, 0, 0};
        vecs[12] = '{1'b0, 36,  2, 0, 2, 1, 0};
        vecs[13] = '{1'b0, 38, 10, 2, 2, 1, 0};
        vecs[14] = '{1'b0, 44,  6, 0, 2, 3, 0};
        vecs[15] = '{1'b0, 45,  7, 1, 2, 3, 0};
        vecs[16] = '{1'b0, 46, 14, 2, 2, 3, 0};
        vecs[17] = '{1'b0, 47, 15, 3, 2, 3, 1};
        vecs[18] = '{1'b1,  0,  0, 0, 0, 0, 0};
        vecs[19] = '{1'b1,  1,  2, 2, 0, 0, 1};
        vecs[20] = '{1'b1, 10,  2, 0, 1, 2, 0};
        vecs[21] = '{1'b1, 11,  6, 2, 1, 2, 1};
        vecs[22] = '{1'b1, 22,  6, 0, 2, 3, 0};
        vecs[23] = '{1'b1, 23, 14, 2, 2, 3, 1};

        nrst = 1'b0;
        a_start = 1'b0; a_ro = 1'b0; a_abort = 1'b0; a_ready = 1'b0;
        b_start = 1'b0; b_ro = 1'b0; b_abort = 1'b0; b_ready = 1'b0;

        // Reset state
        #12;
        check("rst_addr", int'(a_addr), 0);
        check("rst_valid", int'(a_valid), 0);
        check("rst_slot", int'(a_slot), 0);
        check("rst_stage", int'(a_stage), 0);
        check("rst_tw", int'(a_tw), 0);
        check("rst_last", int'(a_last), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_b_addr", int'(b_addr), 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full mode, ready=1, start held into RUN must not restart
        run_a(1'b0, 1'b0, 10, base, d0, ok);
        check_run("full", 1'b0, base, d0, ok, vecs);

        // real_only mode, ready=1
        run_a(1'b1, 1'b0, 0, base, d0, ok);
        check_run("ro", 1'b1, base, d0, ok, vecs);

        // Full mode under random backpressure: same sequence, outputs held while stalled
        hb0 = hold_bad;
        run_a(1'b0, 1'b1, 0, base, d0, ok);
        check_run("bp", 1'b0, base, d0, ok, vecs);
        check("bp_hold_stable", hold_bad - hb0, 0);
        check("bp_stalls_seen", (hold_seen > 0) ? 1 : 0, 1);

        // Abort on the 10th transfer cycle
        d0 = done_cnt;
        @(posedge clk); #1;
        a_start = 1'b1; a_ro = 1'b0; a_ready = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a_abort = 1'b1;
        @(negedge clk);
        check("abort_pre_valid", int'(a_valid), 1);
        check("abort_pre_addr", int'(a_addr), 9);
        @(posedge clk); #1;
        a_abort = 1'b0;
        @(negedge clk);
        check("abort_valid", int'(a_valid), 0);
        check("abort_busy", int'(a_busy), 0);
        check("abort_done", int'(a_done), 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        @(negedge clk);
        check("restart_valid", int'(a_valid), 1);
        check("restart_addr", int'(a_addr), 0);
        check("restart_slot", int'(a_slot), 0);
        check("restart_stage", int'(a_stage), 0);
        @(posedge clk); #1;
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;

        // Async reset mid-RUN
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("prerst_valid", int'(a_valid), 1);
        nrst = 1'b0;
        #1;
        check("arst_addr", int'(a_addr), 0);
        check("arst_valid", int'(a_valid), 0);
        check("arst_slot", int'(a_slot), 0);
        check("arst_stage", int'(a_stage), 0);
        check("arst_tw", int'(a_tw), 0);
        check("arst_busy", int'(a_busy), 0);
        @(negedge clk);
        nrst = 1'b1;
        a_ready = 1'b0;
        @(negedge clk);
        check("post_rst_valid", int'(a_valid), 0);

        // Wrap instance: BASE=1000, sample 12 imag lands on (1000+25) mod 1024
        @(posedge clk); #1;
        b_start = 1'b1; b_ready = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int n = 0; n < 26; n++) begin
            @(negedge clk);
            if (n == 0) begin
                check("wrap_first_valid", int'(b_valid), 1);
                check("wrap_first_addr", int'(b_addr), 1000);
            end
            if (n == 25) begin
                check("wrap_addr", int'(b_addr), 1);
                check("wrap_slot", int'(b_slot), 1);
                check("wrap_stage", int'(b_stage), 0);
                check("wrap_tw", int'(b_tw), 0);
                check("wrap_last", int'(b_last), 0);
                check("wrap_busy", int'(b_busy), 1);
                check("wrap_done", int'(b_done), 0);
            end
        end
        @(posedge clk); #1;
        b_abort = 1'b1;
        @(posedge clk); #1;
        b_abort = 1'b0;
        b_ready = 1'b0;
        @(negedge clk);
        check("wrap_abort_valid", int'(b_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
